// File: rtl/out_packetizer_if.sv
// rtl/out_packetizer_if.sv - output frame stream bundle for out_packetizer
//
// Signals:
//   m_data   [7:0]  frame byte (header, payload or checksum)
//   m_valid         m_data qualifier
//   m_ready         sink accepts the beat when m_valid && m_ready
//   m_last          marks the final byte of a frame
// Modports: master = packetizer side, slave = downstream sink side.
interface out_packetizer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/out_packetizer.sv
// rtl/out_packetizer.sv - byte FIFO plus fixed-length frame emitter
//
// Buffers an unthrottled upstream byte stream and emits frames of
// HDR_BYTE, PKT_LEN payload bytes and (optionally) a checksum trailer.
//
// Optional feature macro: OUT_PACKETIZER_CHECKSUM_EN
//   defined   : frame = header + PKT_LEN payload + 8-bit sum of payload,
//               m_last on the checksum byte
//   undefined : frame = header + PKT_LEN payload, m_last on last payload
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_in     upstream byte
//   valid_in    data_in qualifier (no backpressure upstream)
//   m_if        output stream (master modport of out_packetizer_if)
//   fifo_count  FIFO occupancy
//   overflow    sticky: an input byte was dropped because the FIFO was full
//   ovf_clr     synchronous clear of overflow (a same-cycle drop wins)
module out_packetizer #(
    parameter int         DEPTH    = 16,
    parameter int         PKT_LEN  = 4,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 data_in,
    input  logic                       valid_in,
    out_packetizer_if.master           m_if,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(PKT_LEN + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] PKT_LEN_C = CW'(PKT_LEN);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [BW-1:0] BEAT_LEN  = BW'(PKT_LEN);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM    = 2'd3;
`endif

    logic [1:0]    state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [BW-1:0] beat_q, beat_d;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic       full;
    logic       push;
    logic       pop;
    logic       drop;
    logic       hs;
    logic [7:0] rd_data;

    assign hs      = m_valid_q && m_if.m_ready;
    assign rd_data = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO bookkeeping. A pop in the same cycle frees the slot of a full
    // FIFO, so the incoming byte is accepted instead of dropped.
    // ------------------------------------------------------------------
    always_comb begin
        full = (count_q == DEPTH_C);
        push = valid_in && (!full || pop);
        drop = valid_in && full && !pop;

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        ovf_d = drop || (ovf_q && !ovf_clr);
    end

    // ------------------------------------------------------------------
    // Frame FSM. The output register is only reloaded on a handshake or
    // while empty, so beats hold stable under backpressure. A frame only
    // starts once all payload bytes are buffered, hence pops never
    // underflow.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        beat_d    = beat_q;
        pop       = 1'b0;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                if (count_q >= PKT_LEN_C) begin
                    m_data_d  = HDR_BYTE;
                    m_valid_d = 1'b1;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = ST_HDR;
                end
            end

            ST_HDR: begin
                if (hs) begin
                    pop      = 1'b1;
                    m_data_d = rd_data;
                    beat_d   = BEAT_ONE;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
                    csum_d   = rd_data;
                    m_last_d = 1'b0;
`else
                    m_last_d = (BEAT_ONE == BEAT_LEN);
`endif
                    state_d  = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (hs) begin
                    if (beat_q < BEAT_LEN) begin
                        pop      = 1'b1;
                        m_data_d = rd_data;
                        beat_d   = beat_q + BEAT_ONE;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
                        csum_d   = csum_q + rd_data;
`else
                        m_last_d = (beat_q + BEAT_ONE == BEAT_LEN);
`endif
                    end else begin
`ifdef OUT_PACKETIZER_CHECKSUM_EN
                        m_data_d  = csum_q;
                        m_last_d  = 1'b1;
                        state_d   = ST_CSUM;
`else
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = ST_IDLE;
`endif
                    end
                end
            end

`ifdef OUT_PACKETIZER_CHECKSUM_EN
            ST_CSUM: begin
                if (hs) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif

            default: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // FIFO storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            beat_q    <= '0;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            beat_q    <= beat_d;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign m_if.m_data  = m_data_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_last_q;
    assign fifo_count   = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_out_packetizer.sv
// tb/tb_out_packetizer.sv - self-checking bench for out_packetizer
module tb_out_packetizer;
    localparam int         DEPTH   = 16;
    localparam int         PKT_LEN = 4;
    localparam logic [7:0] HDR     = 8'hA5;
`ifdef OUT_PACKETIZER_CHECKSUM_EN
    localparam int         FLEN    = PKT_LEN + 2;
`else
    localparam int         FLEN    = PKT_LEN + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] fifo_count;
    logic       overflow;

    out_packetizer_if m_if ();

    out_packetizer #(
        .DEPTH   (DEPTH),
        .PKT_LEN (PKT_LEN),
        .HDR_BYTE(HDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .m_if      (m_if),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted bytes are grouped into frames of PKT_LEN;
    // each complete group expands into the expected {last,data} beats.
    logic [8:0] exp_q[$];
    logic [7:0] pend[$];
    bit         mon_en = 1'b0;

    task automatic model_push(input logic [7:0] b);
`ifdef OUT_PACKETIZER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        pend.push_back(b);
        if (pend.size() == PKT_LEN) begin
            exp_q.push_back({1'b0, HDR});
`ifdef OUT_PACKETIZER_CHECKSUM_EN
            sum = 8'h00;
            for (int i = 0; i < PKT_LEN; i++) begin
                sum = sum + pend[i];
                exp_q.push_back({1'b0, pend[i]});
            end
            exp_q.push_back({1'b1, sum});
`else
            for (int i = 0; i < PKT_LEN; i++) begin
                exp_q.push_back({(i == PKT_LEN - 1), pend[i]});
            end
`endif
            pend.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        ok = (exp_q.size() == 0);
        tick();
        tick();
    endtask

    // Output monitor: every handshake beat against the model, and the
    // hold rule after every stalled cycle.
    logic [8:0] mon_exp;
    logic [9:0] prev_beat;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                total++;
                if ({m_if.m_valid, m_if.m_last, m_if.m_data} !== prev_beat) begin
                    bad++;
                    $display("FAIL hold: got %03h want %03h",
                             {m_if.m_valid, m_if.m_last, m_if.m_data}, prev_beat);
                end
            end
            if (m_if.m_valid && m_if.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat: got last=%0b data=%02h, want none",
                             m_if.m_last, m_if.m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({m_if.m_last, m_if.m_data} !== mon_exp) begin
                        bad++;
                        $display("FAIL beat: got last=%0b data=%02h, want last=%0b data=%02h",
                                 m_if.m_last, m_if.m_data, mon_exp[8], mon_exp[7:0]);
                    end
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_beat  = {m_if.m_valid, m_if.m_last, m_if.m_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic test_reset();
        m_if.m_ready = 1'b0;
        #12;
        total++;
        if ({m_if.m_valid, m_if.m_last, m_if.m_data, fifo_count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset: got v=%0b l=%0b d=%02h cnt=%0d ovf=%0b, want all 0",
                     m_if.m_valid, m_if.m_last, m_if.m_data, fifo_count, overflow);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (m_if.m_valid !== 1'b0 || fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL post_reset: got v=%0b cnt=%0d, want 0 0", m_if.m_valid, fifo_count);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4];
        int  seen_cnt = -1;
        int  seen_v = -1;
        bit  ok;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        m_if.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) begin
                valid_in = 1'b1;
                data_in  = bytes[c];
                model_push(bytes[c]);
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (fifo_count >= 5'd4 && seen_cnt < 0) seen_cnt = c;
            if (m_if.m_valid && seen_v < 0) seen_v = c;
        end
        total++;
        if (seen_cnt < 0 || seen_v - seen_cnt != 1) begin
            bad++;
            $display("FAIL hdr_latency: got %0d cycles, want 1", seen_v - seen_cnt);
        end
        wait_drain(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_drain: got %0d beats left, want 0", exp_q.size());
        end
        total++;
        if (fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL basic_count: got %0d want 0", fifo_count);
        end
    endtask

    task automatic test_checksum();
        logic [7:0] bytes [4];
        bit ok;
        bytes[0] = 8'hFF; bytes[1] = 8'hFF; bytes[2] = 8'h02; bytes[3] = 8'h01;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = bytes[i];
            model_push(bytes[i]);
            tick();
        end
        valid_in = 1'b0;
        wait_drain(50, ok);
        total++;
        if (!ok || overflow !== 1'b0) begin
            bad++;
            $display("FAIL csum: got left=%0d ovf=%0b, want 0 0", exp_q.size(), overflow);
        end
    endtask

    task automatic test_stall();
        bit ok;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'h50 + i);
            model_push(8'(8'h50 + i));
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (m_if.m_valid) break;
            tick();
        end
        total++;
        if (m_if.m_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_start: got m_valid=%0b want 1", m_if.m_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (m_if.m_data !== HDR || m_if.m_valid !== 1'b1 || fifo_count !== 5'd4) begin
                bad++;
                $display("FAIL stall_hold: got d=%02h v=%0b cnt=%0d, want a5 1 4",
                         m_if.m_data, m_if.m_valid, fifo_count);
            end
        end
        m_if.m_ready = 1'b1;
        wait_drain(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_drain: got %0d beats left, want 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(i);
            if (i < DEPTH) model_push(8'(i));
            tick();
        end
        valid_in = 1'b0;
        tick();
        total++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%0b, want 16 1", fifo_count, overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: got %0b want 0", overflow);
        end
        ovf_clr  = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hEE;
        tick();
        ovf_clr  = 1'b0;
        valid_in = 1'b0;
        total++;
        if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
            bad++;
            $display("FAIL ovf_set_wins: got ovf=%0b cnt=%0d, want 1 16", overflow, fifo_count);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_if.m_ready = 1'b1;
        wait_drain(200, ok);
        total++;
        if (!ok || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_drain: got left=%0d cnt=%0d ovf=%0b, want 0 0 0",
                     exp_q.size(), fifo_count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        bit rec [40];
        int ph = 0, r1 = 0, gap = 0, r2 = 0;
        bit ok;
        logic [7:0] b;
        m_if.m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) begin
                b = 8'($urandom);
                valid_in = 1'b1;
                data_in  = b;
                model_push(b);
            end else begin
                valid_in = 1'b0;
            end
            tick();
            rec[c] = m_if.m_valid;
        end
        for (int c = 0; c < 40; c++) begin
            case (ph)
                0: if (rec[c]) begin ph = 1; r1 = 1; end
                1: if (rec[c]) r1++; else begin ph = 2; gap = 1; end
                2: if (!rec[c]) gap++; else begin ph = 3; r2 = 1; end
                3: if (rec[c]) r2++; else ph = 4;
                default: ;
            endcase
        end
        total++;
        if (r1 != FLEN || gap != 1 || r2 != FLEN) begin
            bad++;
            $display("FAIL b2b: got run1=%0d gap=%0d run2=%0d, want %0d 1 %0d",
                     r1, gap, r2, FLEN, FLEN);
        end
        wait_drain(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_drain: got %0d beats left, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit saw = 1'b0;
        bit ok;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'hC0 + i);
            tick();
        end
        valid_in = 1'b0;
        tick();
        mon_en = 1'b0;
        exp_q.delete();
        pend.delete();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_if.m_valid, m_if.m_last, m_if.m_data, fifo_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got v=%0b l=%0b d=%02h cnt=%0d, want 0 0 00 0",
                     m_if.m_valid, m_if.m_last, m_if.m_data, fifo_count);
        end
        tick();
        rst_n = 1'b1;
        m_if.m_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'h70 + i);
            model_push(8'(8'h70 + i));
            tick();
            saw |= m_if.m_valid;
        end
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw |= m_if.m_valid;
        end
        total++;
        if (saw || fifo_count !== 5'd2) begin
            bad++;
            $display("FAIL reset_partial: got valid_seen=%0b cnt=%0d, want 0 2", saw, fifo_count);
        end
        for (int i = 2; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'h70 + i);
            model_push(8'(8'h70 + i));
            tick();
        end
        valid_in = 1'b0;
        wait_drain(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_refill: got %0d beats left, want 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int n, sent, cyc;
        logic [7:0] b;
        for (int r = 0; r < 8; r++) begin
            n = PKT_LEN * $urandom_range(1, 3);
            sent = 0;
            while (sent < n) begin
                m_if.m_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0) begin
                    b = 8'($urandom);
                    valid_in = 1'b1;
                    data_in  = b;
                    model_push(b);
                    sent++;
                end else begin
                    valid_in = 1'b0;
                end
                tick();
            end
            valid_in = 1'b0;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 400) begin
                m_if.m_ready = ($urandom_range(0, 3) != 0);
                tick();
                cyc++;
            end
            m_if.m_ready = 1'b1;
            tick();
            tick();
            total++;
            if (exp_q.size() != 0 || overflow !== 1'b0 || fifo_count !== 5'd0) begin
                bad++;
                $display("FAIL random_round%0d: got left=%0d ovf=%0b cnt=%0d, want 0 0 0",
                         r, exp_q.size(), overflow, fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
